// File: rtl/frs_pkg.sv
// Shared types and constants for the FRS Message queue: message layout,
// register bit positions and the FRS Reason encodings.
package frs_pkg;

  localparam int FRS_MSG_W = 20;

  // Packed so that {reason, function_id} lines up with msg_data[19:0]
  typedef struct packed {
    logic [3:0]  reason;
    logic [15:0] function_id;
  } frs_msg_t;

  localparam int STATUS_RECEIVED_BIT = 0;
  localparam int STATUS_OVERFLOW_BIT = 1;
  localparam int CTRL_INT_EN_BIT     = 0;

  typedef enum logic [3:0] {
    FRS_REASON_UNKNOWN   = 4'h0,
    FRS_REASON_DRS_RCVD  = 4'h1,
    FRS_REASON_D3HOT_D0  = 4'h2,
    FRS_REASON_FLR_DONE  = 4'h3
  } frs_reason_e;

  function automatic frs_msg_t frs_unpack(input logic [FRS_MSG_W-1:0] raw);
    frs_msg_t m;
    m.reason      = raw[19:16];
    m.function_id = raw[15:0];
    return m;
  endfunction

endpackage

// File: rtl/frs_msg_fifo.sv
// Circular buffer of FRS Messages. Pop is applied before push so a full
// queue can accept a new entry in the same cycle it releases one.
module frs_msg_fifo
  import frs_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  frs_msg_t                     push_data,
  input  logic                         pop,
  output frs_msg_t                     head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         dropped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  frs_msg_t         mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic push_ok_s;
  logic pop_ok_s;

  assign empty     = (count_r == {CNT_W{1'b0}});
  assign full      = (count_r == CNT_W'(DEPTH));
  assign pop_ok_s  = pop & ~flush & ~empty;
  assign push_ok_s = push & ~flush & (~full | pop);
  assign dropped   = push & ~flush & full & ~pop;
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];

  // Entry storage: written on accepted push, never reset
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at a power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/frs_message_queue.sv
// FRS Message queue register block: Status (RW1C), Control (int_en) and
// the Message Queue head register, with a one-cycle interrupt pulse.
module frs_message_queue
  import frs_pkg::*;
#(
  parameter int QUEUE_DEPTH    = 8,
  parameter int REGISTER_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               link_dl_down,
  input  logic                               msg_valid,
  input  logic [FRS_MSG_W-1:0]               msg_data,
  input  logic [REGISTER_WIDTH-1:0]          write_data,
  input  logic                               status_we,
  input  logic                               ctrl_we,
  input  logic                               queue_we,
  output logic [REGISTER_WIDTH-1:0]          status_rdata,
  output logic [REGISTER_WIDTH-1:0]          ctrl_rdata,
  output logic [REGISTER_WIDTH-1:0]          queue_rdata,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count,
  output logic                               irq
);

  frs_msg_t               fifo_head_s;
  logic [FRS_MSG_W-1:0]   head_raw_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic                   fifo_drop_s;

  logic received_r;
  logic overflow_r;
  logic int_en_r;
  logic irq_r;

  logic received_n_s;
  logic overflow_n_s;
  logic int_en_n_s;
  logic irq_n_s;
  logic unused_wdata_s;

  frs_msg_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (link_dl_down),
    .push      (msg_valid),
    .push_data (frs_unpack(msg_data)),
    .pop       (queue_we),
    .head      (fifo_head_s),
    .count     (queue_count),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .dropped   (fifo_drop_s)
  );

  assign head_raw_s    = fifo_head_s;
  assign unused_wdata_s = ^{write_data[REGISTER_WIDTH-1:2], fifo_full_s};

  // Stale storage is hidden whenever the queue holds nothing
  assign queue_rdata  = fifo_empty_s ? {REGISTER_WIDTH{1'b0}} : REGISTER_WIDTH'(head_raw_s);
  assign status_rdata = REGISTER_WIDTH'({overflow_r, received_r});
  assign ctrl_rdata   = REGISTER_WIDTH'(int_en_r);
  assign irq          = irq_r;

  // Next-state for status/control; sets beat RW1C clears, DL_Down beats everything but int_en
  always_comb begin
    received_n_s = received_r;
    overflow_n_s = overflow_r;
    int_en_n_s   = int_en_r;
    irq_n_s      = 1'b0;
    if (ctrl_we) begin
      int_en_n_s = write_data[CTRL_INT_EN_BIT];
    end else begin
      int_en_n_s = int_en_r;
    end
    if (link_dl_down) begin
      received_n_s = 1'b0;
      overflow_n_s = 1'b0;
      irq_n_s      = 1'b0;
    end else begin
      received_n_s = msg_valid |
                     (received_r & ~(status_we & write_data[STATUS_RECEIVED_BIT]));
      overflow_n_s = fifo_drop_s |
                     (overflow_r & ~(status_we & write_data[STATUS_OVERFLOW_BIT]));
      // Pulse only on the rising edge of (int_en & received)
      irq_n_s      = int_en_n_s & received_n_s & ~(int_en_r & received_r);
    end
  end

  // Register state and the interrupt pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      received_r <= 1'b0;
      overflow_r <= 1'b0;
      int_en_r   <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      received_r <= received_n_s;
      overflow_r <= overflow_n_s;
      int_en_r   <= int_en_n_s;
      irq_r      <= irq_n_s;
    end
  end

endmodule

// File: tb/tb_frs_message_queue.sv
// Bench for frs_message_queue: directed vector table, corner-case sequences
// and randomized traffic checked against a queue-based reference model.
module tb_frs_message_queue;

  localparam int DEPTH = 8;
  localparam int RW    = 32;

  logic          clk;
  logic          rst_n;
  logic          link_dl_down;
  logic          msg_valid;
  logic [19:0]   msg_data;
  logic [RW-1:0] write_data;
  logic          status_we;
  logic          ctrl_we;
  logic          queue_we;
  logic [RW-1:0] status_rdata;
  logic [RW-1:0] ctrl_rdata;
  logic [RW-1:0] queue_rdata;
  logic [3:0]    queue_count;
  logic          irq;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [19:0] m_q[$];
  logic        m_rec, m_ov, m_int, m_irq;

  typedef struct packed {
    logic        mv;
    logic [19:0] md;
    logic        qwe;
    logic        swe;
    logic        cwe;
    logic [31:0] wd;
    logic        dl;
    logic [3:0]  e_cnt;
    logic [31:0] e_q;
    logic [31:0] e_st;
    logic [31:0] e_ct;
    logic        e_irq;
  } vec_t;

  vec_t vecs[13];

  frs_message_queue #(.QUEUE_DEPTH(DEPTH), .REGISTER_WIDTH(RW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .link_dl_down (link_dl_down),
    .msg_valid    (msg_valid),
    .msg_data     (msg_data),
    .write_data   (write_data),
    .status_we    (status_we),
    .ctrl_we      (ctrl_we),
    .queue_we     (queue_we),
    .status_rdata (status_rdata),
    .ctrl_rdata   (ctrl_rdata),
    .queue_rdata  (queue_rdata),
    .queue_count  (queue_count),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rec = 1'b0;
    m_ov  = 1'b0;
    m_int = 1'b0;
    m_irq = 1'b0;
  endtask

  // One clock edge of the block, from the register-level rules
  task automatic model_edge();
    logic rec_n, ov_n, int_n, ov_set;
    int_n  = ctrl_we ? write_data[0] : m_int;
    ov_set = 1'b0;
    if (link_dl_down) begin
      m_q.delete();
      rec_n = 1'b0;
      ov_n  = 1'b0;
      m_irq = 1'b0;
    end else begin
      if (queue_we && m_q.size() > 0) void'(m_q.pop_front());
      if (msg_valid) begin
        if (m_q.size() < DEPTH) m_q.push_back(msg_data);
        else ov_set = 1'b1;
      end
      rec_n = msg_valid | (m_rec & !(status_we && write_data[0]));
      ov_n  = ov_set | (m_ov & !(status_we && write_data[1]));
      m_irq = (int_n && rec_n) && !(m_int && m_rec);
    end
    m_rec = rec_n;
    m_ov  = ov_n;
    m_int = int_n;
  endtask

  task automatic check_all(input string tag);
    chk({tag, " count"},  32'(queue_count), 32'(m_q.size()));
    chk({tag, " qrdata"}, queue_rdata, (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
    chk({tag, " status"}, status_rdata, {30'h0, m_ov, m_rec});
    chk({tag, " ctrl"},   ctrl_rdata, {31'h0, m_int});
    chk({tag, " irq"},    32'(irq), 32'(m_irq));
  endtask

  task automatic step(input logic mv, input logic [19:0] md, input logic qwe,
                      input logic swe, input logic cwe, input logic [31:0] wd,
                      input logic dl);
    msg_valid = mv;  msg_data = md;   queue_we = qwe;
    status_we = swe; ctrl_we  = cwe;  write_data = wd;
    link_dl_down = dl;
    @(posedge clk);
    model_edge();
    #1;
    msg_valid = 1'b0; queue_we = 1'b0; status_we = 1'b0;
    ctrl_we = 1'b0; link_dl_down = 1'b0; write_data = 32'h0;
  endtask

  task automatic push(input logic [19:0] md);
    step(1'b1, md, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 20'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic flush();
    step(1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    //        mv    md        qwe   swe   cwe   wd            dl    cnt   qdata        status ctrl   irq
    vecs[0]  = '{1'b0, 20'h0,     1'b0, 1'b0, 1'b1, 32'h1,        1'b0, 4'd0, 32'h0,       32'h0, 32'h1, 1'b0};
    vecs[1]  = '{1'b1, 20'h10100, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 4'd1, 32'h10100,   32'h1, 32'h1, 1'b1};
    vecs[2]  = '{1'b1, 20'h10101, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 4'd2, 32'h10100,   32'h1, 32'h1, 1'b0};
    vecs[3]  = '{1'b1, 20'h10102, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 4'd3, 32'h10100,   32'h1, 32'h1, 1'b0};
    vecs[4]  = '{1'b0, 20'h0,     1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 4'd2, 32'h10101,   32'h1, 32'h1, 1'b0};
    vecs[5]  = '{1'b0, 20'h0,     1'b0, 1'b1, 1'b0, 32'h1,        1'b0, 4'd2, 32'h10101,   32'h0, 32'h1, 1'b0};
    vecs[6]  = '{1'b1, 20'h10103, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 4'd3, 32'h10101,   32'h1, 32'h1, 1'b1};
    vecs[7]  = '{1'b1, 20'h10104, 1'b0, 1'b1, 1'b0, 32'h1,        1'b0, 4'd4, 32'h10101,   32'h1, 32'h1, 1'b0};
    vecs[8]  = '{1'b0, 20'h0,     1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 4'd4, 32'h10101,   32'h1, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 20'h0,     1'b0, 1'b0, 1'b1, 32'h1,        1'b0, 4'd4, 32'h10101,   32'h1, 32'h1, 1'b1};
    vecs[10] = '{1'b0, 20'h0,     1'b0, 1'b0, 1'b1, 32'h1,        1'b0, 4'd4, 32'h10101,   32'h1, 32'h1, 1'b0};
    vecs[11] = '{1'b0, 20'h0,     1'b0, 1'b1, 1'b0, 32'h3,        1'b0, 4'd4, 32'h10101,   32'h0, 32'h1, 1'b0};
    vecs[12] = '{1'b0, 20'h0,     1'b0, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 4'd4, 32'h10101,   32'h0, 32'h0, 1'b0};

    rst_n = 1'b0; link_dl_down = 1'b0; msg_valid = 1'b0; msg_data = 20'h0;
    write_data = 32'h0; status_we = 1'b0; ctrl_we = 1'b0; queue_we = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    #11 rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].mv, vecs[i].md, vecs[i].qwe, vecs[i].swe, vecs[i].cwe, vecs[i].wd, vecs[i].dl);
      chk($sformatf("vec%0d count", i),  32'(queue_count), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d qrdata", i), queue_rdata, vecs[i].e_q);
      chk($sformatf("vec%0d status", i), status_rdata, vecs[i].e_st);
      chk($sformatf("vec%0d ctrl", i),   ctrl_rdata, vecs[i].e_ct);
      chk($sformatf("vec%0d irq", i),    32'(irq), 32'(vecs[i].e_irq));
    end

    // Overflow on full: message discarded, head unchanged
    flush();
    chk("ovf flush count", 32'(queue_count), 32'h0);
    for (int i = 0; i < DEPTH; i++) push(20'h10300 + 20'(i));
    push(20'h10200);
    chk("ovf count", 32'(queue_count), 32'd8);
    chk("ovf status", status_rdata, 32'h3);
    chk("ovf head", queue_rdata, 32'h10300);
    for (int i = 0; i < DEPTH; i++) begin
      check_all("ovf drain");
      pop();
    end
    chk("ovf drained count", 32'(queue_count), 32'h0);

    // Push+pop on full, then pop on empty
    for (int i = 0; i < DEPTH; i++) push(20'h10400 + 20'(i));
    step(1'b0, 20'h0, 1'b0, 1'b1, 1'b0, 32'h3, 1'b0);
    step(1'b1, 20'h10777, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("pp count", 32'(queue_count), 32'd8);
    chk("pp status", status_rdata, 32'h1);
    chk("pp head", queue_rdata, 32'h10401);
    for (int i = 0; i < DEPTH - 1; i++) pop();
    chk("pp last head", queue_rdata, 32'h10777);
    chk("pp last count", 32'(queue_count), 32'd1);
    pop();
    pop();
    chk("empty pop count", 32'(queue_count), 32'h0);
    chk("empty pop qrdata", queue_rdata, 32'h0);
    chk("empty pop status", status_rdata, 32'h1);

    // DL_Down with 5 entries and both status bits set
    step(1'b0, 20'h0, 1'b0, 1'b0, 1'b1, 32'h1, 1'b0);
    check_all("dl int_en");
    for (int i = 0; i < DEPTH; i++) push(20'h10500 + 20'(i));
    push(20'h10200);
    for (int i = 0; i < 3; i++) pop();
    chk("dl pre count", 32'(queue_count), 32'd5);
    chk("dl pre status", status_rdata, 32'h3);
    step(1'b1, 20'h10600, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("dl count", 32'(queue_count), 32'h0);
    chk("dl status", status_rdata, 32'h0);
    chk("dl ctrl", ctrl_rdata, 32'h1);
    chk("dl irq", 32'(irq), 32'h0);
    chk("dl qrdata", queue_rdata, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 9) < 6), 20'($urandom), ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 19) < 3), ($urandom_range(0, 19) < 2), 32'($urandom),
           ($urandom_range(0, 39) == 0));
      check_all($sformatf("rand%0d", n));
    end

    // Asynchronous reset mid-push at count 4
    flush();
    for (int i = 0; i < 4; i++) push(20'h10800 + 20'(i));
    chk("rst pre count", 32'(queue_count), 32'd4);
    msg_valid = 1'b1; msg_data = 20'h30900;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async rst");
    #3 rst_n = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
    msg_valid = 1'b0;
    chk("post rst count", 32'(queue_count), 32'd1);
    chk("post rst qrdata", queue_rdata, 32'h30900);
    check_all("post rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frs_message_queue.md
FRS_MESSAGE_QUEUE -- requirements
Module: frs_message_queue

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 8, meaning number of queued FRS Message entries (>=2, power of two).
REQ-002 SHALL have parameter REGISTER_WIDTH, default 32, meaning width of the register read/write data paths (>=20).
REQ-003 SHALL have port clk, input, 1, meaning the single block clock.
REQ-004 SHALL have port rst_n, input, 1, meaning an asynchronous, active-low reset.
REQ-005 SHALL have port link_dl_down, input, 1, meaning the Link is in DL_Down.
REQ-006 SHALL have port msg_valid, input, 1, meaning an FRS Message is received or generated this cycle.
REQ-007 SHALL have port msg_data, input, 20, meaning [15:0] Function ID and [19:16] FRS Reason.
REQ-008 SHALL have port write_data, input, REGISTER_WIDTH, meaning data shared by all register writes.
REQ-009 SHALL have ports status_we, ctrl_we and queue_we, input, 1 each, meaning writes to Status, Control and Message Queue.
REQ-010 SHALL have port status_rdata, output, REGISTER_WIDTH, meaning {RsvdZ, overflow[1], received[0]}.
REQ-011 SHALL have port ctrl_rdata, output, REGISTER_WIDTH, meaning {RsvdP, int_en[0]}.
REQ-012 SHALL have port queue_rdata, output, REGISTER_WIDTH, meaning {RsvdZ, reason[19:16], function_id[15:0]} of the oldest entry.
REQ-013 SHALL have port queue_count, output, $clog2(QUEUE_DEPTH+1), meaning the number of valid entries.
REQ-014 SHALL have port irq, output, 1, meaning a one-cycle interrupt request pulse.

Function
REQ-015 The block SHALL accept msg_valid when count<QUEUE_DEPTH by appending msg_data at the tail, visible on queue_count one cycle later.
REQ-016 If msg_valid arrives while full with no pop, the block SHALL discard the message, leave the queue unchanged and set overflow.
REQ-017 Every msg_valid, accepted or discarded, SHALL set received.
REQ-018 queue_we SHALL pop the oldest entry regardless of write_data, and a pop while empty SHALL be ignored.
REQ-019 On simultaneous push and pop while full, the pop SHALL occur first, the push SHALL be accepted, the count SHALL stay QUEUE_DEPTH and there SHALL be no overflow.
REQ-020 On simultaneous push and pop while empty, the push SHALL be accepted, the pop ignored and the count SHALL become 1.
REQ-021 queue_rdata SHALL be driven directly from registered head-entry state with zero latency, and SHALL read 0 when empty.
REQ-022 The received and overflow bits SHALL be RW1C via status_we with write_data[0]/[1], and a set in the same cycle SHALL win over a clear.
REQ-023 int_en SHALL be RW via ctrl_we with write_data[0], and RsvdP bits SHALL read 0.
REQ-024 irq SHALL pulse for one cycle when int_en=1 and received rises 0->1.
REQ-025 irq SHALL also pulse when int_en is written 0->1 while received=1.
REQ-026 irq SHALL NOT re-pulse while received stays 1.
REQ-027 link_dl_down SHALL, next edge, flush the queue (count 0, pointers 0) and clear received and overflow.
REQ-028 link_dl_down SHALL dominate msg_valid, queue_we and status_we, SHALL leave int_en unchanged and SHALL suppress irq.
REQ-029 Pointers SHALL wrap modulo QUEUE_DEPTH, and the count SHALL never exceed QUEUE_DEPTH.

Reset
REQ-030 On rst_n low (async), the block SHALL reset queue_count=0, pointers=0, received=0, overflow=0, int_en=0 and irq=0, and all rdata SHALL read 0.
REQ-031 Reset deassertion SHALL be synchronous to clk, and the first valid push SHALL be on the first edge after deassertion.
REQ-032 Queue storage contents SHALL need no reset and SHALL never be observable when invalid.

Structure
REQ-033 Package frs_pkg SHALL hold the frs_msg_t struct (function_id[15:0], reason[3:0]), the status/control bit-position constants and the FRS Reason codes.
REQ-034 Sub-module frs_msg_fifo SHALL hold the circular buffer (push, pop, full, empty, count, head), and the top level SHALL hold the registers and irq.

Verification
REQ-035 The bench SHALL push 3 messages (ID 0x0100/0x0101/0x0102, reason 1) -> count=3, queue_rdata=0x10100; after one pop -> 0x10101.
REQ-036 The bench SHALL fill to 8 then push ID 0x0200 -> overflow=1, count=8, the head is unchanged and 0x0200 never appears.
REQ-037 The bench SHALL, with int_en=1, push 1 message -> one irq pulse; a 2nd push -> no irq; clearing received with write 0x1 then pushing -> irq.
REQ-038 The bench SHALL, on full, push+pop in the same cycle -> count=8, overflow=0, and the new entry is last; on empty, pop alone -> count=0 and no change.
REQ-039 The bench SHALL, with 5 entries and both status bits set, assert link_dl_down together with msg_valid -> count=0, status_rdata=0, int_en kept.
REQ-040 The bench SHALL assert rst_n mid-push at count 4 -> all outputs 0 asynchronously, and the first push after release gives count=1.
